factor_search_ctrl: RTL

//  Sequential controller that finds a nontrivial factor pair f1*f2 == target (f1,f2 in [2, 2^W-1], f1<=f2).

---
 rtl/factor_pkg.sv | 15 +
 rtl/factor_search_ctrl_if.sv | 25 ++
 rtl/seq_mult_shift_add.sv | 61 ++++++
 rtl/factor_search_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/factor_pkg.sv
// Shared state encoding and search constants for the factor search controller.
package factor_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned MIN_FACTOR = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_INIT   = 3'd1;
  localparam state_t ST_MUL    = 3'd2;
  localparam state_t ST_CMP    = 3'd3;
  localparam state_t ST_RESULT = 3'd4;

endpackage

// File: rtl/factor_search_ctrl_if.sv
// Request/result handshake bundle between a requester and the factor search controller.
interface factor_search_ctrl_if #(parameter int unsigned W = 6);

  logic             req_valid;
  logic             req_ready;
  logic [2*W-1:0]   req_target;
  logic             abort;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic             res_found;
  logic [W-1:0]     res_f1;
  logic [W-1:0]     res_f2;

  modport master (
    output req_valid, req_target, abort, res_ready,
    input  req_ready, busy, res_valid, res_found, res_f1, res_f2
  );

  modport slave (
    input  req_valid, req_target, abort, res_ready,
    output req_ready, busy, res_valid, res_found, res_f1, res_f2
  );

endinterface

// File: rtl/seq_mult_shift_add.sv
// LSB-first shift-add multiplier: W cycles per product, start loads and performs the first step.
module seq_mult_shift_add #(
  parameter int unsigned W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           clear,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = $clog2(W + 1);

  logic [PW-1:0] mcand;
  logic [W-1:0]  mplier;
  logic [CW-1:0] cnt;
  logic          running;
  logic [PW-1:0] a_ext;

  assign a_ext = PW'(a);

  // done is high during the cycle that performs the final partial-product step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p       <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (clear) begin
      p       <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      p       <= b[0] ? a_ext : '0;
      mcand   <= a_ext << 1;
      mplier  <= b >> 1;
      cnt     <= CW'(1);
      running <= (W > 1);
      done    <= (W == 2);
    end else if (running) begin
      if (mplier[0]) p <= p + mcand;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      cnt     <= cnt + CW'(1);
      running <= (cnt != CW'(W - 1));
      done    <= (cnt == CW'(W - 2));
    end else begin
      done    <= 1'b0;
    end
  end

endmodule

// File: rtl/factor_search_ctrl.sv
// Walks candidate pairs (f1<=f2) in ascending order and reports the first f1*f2 == target.
module factor_search_ctrl #(
  parameter int unsigned W = 6
) (
  input logic                clk,
  input logic                rst_n,
  factor_search_ctrl_if.slave bus
);

  import factor_pkg::*;

  localparam int unsigned PW    = 2 * W;
  localparam logic [W-1:0] MAX_F = '1;

  state_t         state, state_next;
  logic [PW-1:0]  target, target_n;
  logic [W-1:0]   f1, f1_n, f2, f2_n;
  logic           found_n;
  logic [W-1:0]   rf1_n, rf2_n;
  logic           mult_start;
  logic           mult_done;
  logic [PW-1:0]  prod;
  logic           busy_c;
  logic           mult_clear_c;

  assign busy_c       = (state == ST_INIT) || (state == ST_MUL) || (state == ST_CMP);
  assign mult_clear_c = busy_c && bus.abort;

  seq_mult_shift_add #(.W(W)) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mult_start),
    .clear (mult_clear_c),
    .a     (f1),
    .b     (f2),
    .done  (mult_done),
    .p     (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    target_n   = target;
    f1_n       = f1;
    f2_n       = f2;
    found_n    = bus.res_found;
    rf1_n      = bus.res_f1;
    rf2_n      = bus.res_f2;
    if (mult_clear_c) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            target_n   = bus.req_target;
            state_next = ST_INIT;
          end
        end
        ST_INIT: begin
          if (target < PW'(MIN_FACTOR * MIN_FACTOR)) begin
            found_n    = 1'b0;
            rf1_n      = '0;
            rf2_n      = '0;
            state_next = ST_RESULT;
          end else begin
            f1_n       = W'(MIN_FACTOR);
            f2_n       = W'(MIN_FACTOR);
            state_next = ST_MUL;
          end
        end
        ST_MUL: begin
          if (mult_done) state_next = ST_CMP;
        end
        ST_CMP: begin
          // increments below are only reachable when the incremented factor is below MAX_F
          if (prod == target) begin
            found_n    = 1'b1;
            rf1_n      = f1;
            rf2_n      = f2;
            state_next = ST_RESULT;
          end else if (prod > target && f2 == f1) begin
            found_n    = 1'b0;
            rf1_n      = '0;
            rf2_n      = '0;
            state_next = ST_RESULT;
          end else if (prod > target) begin
            f1_n       = f1 + W'(1);
            f2_n       = f1 + W'(1);
            state_next = ST_MUL;
          end else if (f2 != MAX_F) begin
            f2_n       = f2 + W'(1);
            state_next = ST_MUL;
          end else if (f1 == MAX_F) begin
            found_n    = 1'b0;
            rf1_n      = '0;
            rf2_n      = '0;
            state_next = ST_RESULT;
          end else begin
            f1_n       = f1 + W'(1);
            f2_n       = f1 + W'(1);
            state_next = ST_MUL;
          end
        end
        ST_RESULT: begin
          if (bus.res_ready) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Datapath and registered handshake outputs follow the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target        <= '0;
      f1            <= '0;
      f2            <= '0;
      mult_start    <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_found <= 1'b0;
      bus.res_f1    <= '0;
      bus.res_f2    <= '0;
    end else begin
      target        <= target_n;
      f1            <= f1_n;
      f2            <= f2_n;
      mult_start    <= (state_next == ST_MUL) && (state != ST_MUL);
      bus.req_ready <= (state_next == ST_IDLE);
      bus.busy      <= (state_next == ST_INIT) || (state_next == ST_MUL) ||
                       (state_next == ST_CMP);
      bus.res_valid <= (state_next == ST_RESULT);
      bus.res_found <= found_n;
      bus.res_f1    <= rf1_n;
      bus.res_f2    <= rf2_n;
    end
  end

endmodule
